bcd_stopwatch_ctrl: RTL

Controller that sequences a chain of cascaded BCD digit counters as a start/stop/lap stopwatch. It owns the run/pause/overflow FSM and the tick prescaler, generates per-digit increment enables from lower-digit terminal counts, and captures lap snapshots. It sits between user command pulses (debounced buttons) and the display path.

---
 rtl/bcd_stopwatch_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap stopwatch controller driving a cascade of BCD digit counters.
// Owns the run/pause/overflow FSM, the tick prescaler and lap capture.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 5,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic                  running,
  output logic                  tick,
  output logic [4*DIGITS-1:0]   digits,
  output logic [4*DIGITS-1:0]   lap_digits,
  output logic                  lap_valid,
  output logic                  overflow
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] OVF   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic                lap_valid_q, lap_valid_d;
  logic                ovf_q, ovf_d;
  logic                running_q;

  logic [DIGITS-1:0]   nine;
  logic [DIGITS-1:0]   en;
  logic                all_nines;
  logic [4*DIGITS-1:0] digits_inc;

  assign tick = (state_q == RUN) && (presc_q == PRESC_MAX) && !stop && !clear;

  // Ripple enable: a digit advances only when every lower digit is at 9 on a tick.
  always_comb begin
    nine       = '0;
    en         = '0;
    digits_inc = digits_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nine[i] = (digits_q[4*i +: 4] == 4'd9);
    end
    en[0] = tick;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      en[i] = en[i-1] && nine[i-1];
    end
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (en[i]) begin
        digits_inc[4*i +: 4] = nine[i] ? 4'd0 : digits_q[4*i +: 4] + 4'd1;
      end
    end
    all_nines = &nine;
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    digits_d    = digits_q;
    ovf_d       = ovf_q;
    lap_d       = lap_q;
    lap_valid_d = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      presc_d  = '0;
      digits_d = '0;
      lap_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
            if (tick && all_nines) begin
              state_d = OVF;
              ovf_d   = 1'b1;
            end else begin
              digits_d = digits_inc;
            end
          end
        end
        PAUSE: begin
          if (start && !stop) state_d = RUN;
        end
        OVF: begin
          state_d = OVF;
        end
        default: state_d = IDLE;
      endcase
      // Snapshot uses pre-edge digits, so a coincident increment is excluded.
      if (lap && (state_q == RUN || state_q == PAUSE)) begin
        lap_d       = digits_q;
        lap_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      digits_q    <= '0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      digits_q    <= digits_d;
      lap_q       <= lap_d;
      lap_valid_q <= lap_valid_d;
      ovf_q       <= ovf_d;
      running_q   <= (state_d == RUN);
    end
  end

  assign running    = running_q;
  assign digits     = digits_q;
  assign lap_digits = lap_q;
  assign lap_valid  = lap_valid_q;
  assign overflow   = ovf_q;

endmodule
